// File: rtl/pc_if.sv
// Fetch-control bundle between the fetch sequencer (master) and the program-counter unit (slave).
interface pc_if #(
  parameter int XLEN = 16
);
  logic            stall;
  logic            trap;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_inc;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;
  logic            ras_err;

  modport master (
    output stall, trap, redirect_valid, redirect_target, call, ret,
    input  pc_out, pc_plus_inc, ras_empty, ras_full, misaligned, ras_err
  );

  modport slave (
    input  stall, trap, redirect_valid, redirect_target, call, ret,
    output pc_out, pc_plus_inc, ras_empty, ras_full, misaligned, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with trap/redirect/return/sequential next-PC selection and a
// circular return-address stack that silently overwrites its oldest entry when full.
module pc_unit #(
  parameter int              XLEN      = 16,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(4),
  parameter int              INC       = 2,
  parameter int              RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [PW-1:0]   top_up;
  logic [CW-1:0]   count;
  logic            mis_q;
  logic            err_q;
  logic            push;

  assign pc_next_seq = pc + XLEN'(INC);
  assign top_up      = top + PW'(1);
  assign push        = !rst && !bus.trap && bus.redirect_valid && bus.call;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VEC;
      top   <= '0;
      count <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (bus.trap) begin
        pc <= TRAP_VEC;
      end else if (bus.redirect_valid) begin
        pc    <= bus.redirect_target & ~LOW_MASK;
        mis_q <= |(bus.redirect_target & LOW_MASK);
        if (bus.call) begin
          top <= top_up;
          if (count != FULL_CNT) count <= count + CW'(1);
        end
      end else if (bus.ret) begin
        if (count != '0) begin
          pc    <= ras[top];
          top   <= top - PW'(1);
          count <= count - CW'(1);
        end else begin
          pc    <= TRAP_VEC;
          err_q <= 1'b1;
        end
      end else if (!bus.stall) begin
        pc <= pc_next_seq;
      end
    end
  end

  // Stack storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) ras[top_up] <= pc_next_seq;
  end

  assign bus.pc_out      = pc;
  assign bus.pc_plus_inc = pc_next_seq;
  assign bus.ras_empty   = (count == '0);
  assign bus.ras_full    = (count == FULL_CNT);
  assign bus.misaligned  = mis_q;
  assign bus.ras_err     = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: each stimulus cycle queues the hand-computed
// post-edge state, and an independent monitor pops and compares it after every edge.
module tb_pc_unit;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  pc_if #(.XLEN(16)) bus ();

  pc_unit #(
    .XLEN(16), .RESET_VEC(16'h0000), .TRAP_VEC(16'h0004), .INC(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected right after the coming edge.
  task automatic applyStimulus(input string tag, input logic r, input logic st, input logic tr,
                               input logic rv, input logic [15:0] tgt, input logic cl, input logic rt,
                               input logic [15:0] ePc, input logic eE, input logic eF,
                               input logic eM, input logic eR);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    bus.stall           = st;
    bus.trap            = tr;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.call            = cl;
    bus.ret             = rt;
    e.tag = tag; e.pc = ePc; e.empty = eE; e.full = eF; e.mis = eM; e.err = eR;
    sbq.push_back(e);
  endtask

  // Monitor: independent of stimulus, checks the DUT after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput({e.tag, ".pc_out"},      bus.pc_out,              e.pc);
        checkOutput({e.tag, ".pc_plus_inc"}, bus.pc_plus_inc,         e.pc + 16'd2);
        checkOutput({e.tag, ".ras_empty"},   16'(bus.ras_empty),      16'(e.empty));
        checkOutput({e.tag, ".ras_full"},    16'(bus.ras_full),       16'(e.full));
        checkOutput({e.tag, ".misaligned"},  16'(bus.misaligned),     16'(e.mis));
        checkOutput({e.tag, ".ras_err"},     16'(bus.ras_err),        16'(e.err));
      end
    end
  end

  initial begin
    int waitCycles;
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.trap = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_target = '0; bus.call = 1'b0; bus.ret = 1'b0;

    //             tag          rst st tr rv tgt       cl rt  pc        E  F  M  R
    applyStimulus("rst0",       1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);
    applyStimulus("rst1",       1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);
    applyStimulus("seq1",       0, 0, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0, 0);
    applyStimulus("seq2",       0, 0, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0, 0, 0);
    applyStimulus("seq3",       0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 1, 0, 0, 0);
    applyStimulus("seq4",       0, 0, 0, 0, 16'h0000, 0, 0, 16'h0008, 1, 0, 0, 0);
    applyStimulus("midrst",     1, 0, 0, 1, 16'h0300, 1, 0, 16'h0000, 1, 0, 0, 0);
    // Stall and wrap-around
    applyStimulus("pre_fffc",   0, 0, 0, 1, 16'hFFFC, 0, 0, 16'hFFFC, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall",    0, 1, 0, 0, 16'h0000, 0, 0, 16'hFFFC, 1, 0, 0, 0);
    applyStimulus("to_fffe",    0, 0, 0, 0, 16'h0000, 0, 0, 16'hFFFE, 1, 0, 0, 0);
    applyStimulus("wrap",       0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);
    // Single call and return
    applyStimulus("go_0010",    0, 0, 0, 1, 16'h0010, 0, 0, 16'h0010, 1, 0, 0, 0);
    applyStimulus("call_100",   0, 0, 0, 1, 16'h0100, 1, 0, 16'h0100, 0, 0, 0, 0);
    applyStimulus("run_102",    0, 0, 0, 0, 16'h0000, 0, 0, 16'h0102, 0, 0, 0, 0);
    applyStimulus("run_104",    0, 0, 0, 0, 16'h0000, 0, 0, 16'h0104, 0, 0, 0, 0);
    applyStimulus("ret_012",    0, 0, 0, 0, 16'h0000, 0, 1, 16'h0012, 1, 0, 0, 0);
    // Overflow: five nested calls into a four-entry stack
    applyStimulus("ovf_go10",   0, 0, 0, 1, 16'h0010, 0, 0, 16'h0010, 1, 0, 0, 0);
    applyStimulus("ovf_c1",     0, 0, 0, 1, 16'h0020, 1, 0, 16'h0020, 0, 0, 0, 0);
    applyStimulus("ovf_c2",     0, 0, 0, 1, 16'h0030, 1, 0, 16'h0030, 0, 0, 0, 0);
    applyStimulus("ovf_c3",     0, 0, 0, 1, 16'h0040, 1, 0, 16'h0040, 0, 0, 0, 0);
    applyStimulus("ovf_c4",     0, 0, 0, 1, 16'h0050, 1, 0, 16'h0050, 0, 1, 0, 0);
    applyStimulus("ovf_c5",     0, 0, 0, 1, 16'h0060, 1, 1, 16'h0060, 0, 1, 0, 0);
    applyStimulus("ovf_r1",     0, 0, 0, 0, 16'h0000, 0, 1, 16'h0052, 0, 0, 0, 0);
    applyStimulus("ovf_r2",     0, 0, 0, 0, 16'h0000, 0, 1, 16'h0042, 0, 0, 0, 0);
    applyStimulus("ovf_r3",     0, 1, 0, 0, 16'h0000, 0, 1, 16'h0032, 0, 0, 0, 0);
    applyStimulus("ovf_r4",     0, 0, 0, 0, 16'h0000, 0, 1, 16'h0022, 1, 0, 0, 0);
    applyStimulus("ovf_r5",     0, 0, 0, 0, 16'h0000, 0, 1, 16'h0004, 1, 0, 0, 1);
    applyStimulus("err_hold",   0, 0, 0, 0, 16'h0000, 0, 0, 16'h0006, 1, 0, 0, 1);
    // Priority: trap beats redirect/call/stall, redirect beats stall
    applyStimulus("pri_call",   0, 0, 0, 1, 16'h0300, 1, 0, 16'h0300, 0, 0, 0, 1);
    applyStimulus("pri_trap",   0, 1, 1, 1, 16'h0200, 1, 1, 16'h0004, 0, 0, 0, 1);
    applyStimulus("pri_redir",  0, 1, 0, 1, 16'h0200, 0, 0, 16'h0200, 0, 0, 0, 1);
    applyStimulus("pri_ret",    0, 1, 0, 0, 16'h0000, 0, 1, 16'h0008, 1, 0, 0, 1);
    // Misalignment pulse
    applyStimulus("mis_123",    0, 0, 0, 1, 16'h0123, 0, 0, 16'h0122, 1, 0, 1, 1);
    applyStimulus("mis_clear",  0, 0, 0, 0, 16'h0000, 0, 0, 16'h0124, 1, 0, 0, 1);
    applyStimulus("mis_124",    0, 0, 0, 1, 16'h0124, 0, 0, 16'h0124, 1, 0, 0, 1);
    applyStimulus("final_rst",  1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    waitCycles = 0;
    while (sbq.size() > 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (sbq.size() > 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
